// File: rtl/mult_seq_feeder_if.sv
// Handshake/stream bundle for mult_seq_feeder: a packed pair of input vectors
// with a valid/ready accept, and a strobed product stream with last/busy flags.
interface mult_seq_feeder_if #(
    parameter int pDATA_IN_W       = 8,
    parameter int pNUM_OF_ELEMENTS = 9
);
    logic [pNUM_OF_ELEMENTS*pDATA_IN_W-1:0] idata_a;
    logic [pNUM_OF_ELEMENTS*pDATA_IN_W-1:0] idata_b;
    logic                                   ivalid;
    logic                                   oready;
    logic [2*pDATA_IN_W-1:0]                odata;
    logic                                   odata_en;
    logic                                   olast;
    logic                                   obusy;

    // Producer of vectors / consumer of products
    modport master (
        output idata_a, idata_b, ivalid,
        input  oready, odata, odata_en, olast, obusy
    );

    // The multiply feeder itself
    modport slave (
        input  idata_a, idata_b, ivalid,
        output oready, odata, odata_en, olast, obusy
    );
endinterface

// File: rtl/mult_seq_feeder.sv
// Sequential multiply front-end: captures one pair of element vectors and
// streams their element-wise full-precision products, one per clock, with a
// strobe and a last flag on the final product. No backpressure downstream.
module mult_seq_feeder #(
    parameter int pDATA_IN_W       = 8,
    parameter int pNUM_OF_ELEMENTS = 9,
    parameter bit pSIGNED          = 1'b1
) (
    input  logic             iclk,
    input  logic             irst,
    mult_seq_feeder_if.slave bus
);
    localparam int W     = pDATA_IN_W;
    localparam int N     = pNUM_OF_ELEMENTS;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;

    // Captured operand vectors, one register per element
    logic [W-1:0] vec_a_reg [N];
    logic [W-1:0] vec_b_reg [N];

    // Element selected by the counter, widened to product width
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;
    logic [2*W-1:0] ext_a;
    logic [2*W-1:0] ext_b;
    logic [2*W-1:0] prod;

    // Registered outputs
    logic [2*W-1:0] odata_reg;
    logic           odata_en_reg;
    logic           olast_reg;
    logic           oready_reg;
    logic           obusy_reg;

    // A vector is taken only while idle; anything offered during RUN is dropped
    logic capture;
    assign capture = (state_reg == IDLE) && bus.ivalid;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_vec
            // Load element gi of both vectors on accept so inputs need not be held
            always_ff @(posedge iclk or posedge irst) begin
                if (irst) begin
                    vec_a_reg[gi] <= '0;
                    vec_b_reg[gi] <= '0;
                end else if (capture) begin
                    vec_a_reg[gi] <= bus.idata_a[gi*W +: W];
                    vec_b_reg[gi] <= bus.idata_b[gi*W +: W];
                end
            end
        end
    endgenerate

    // Pick the operand pair addressed by the element counter
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N; i++) begin
            if (cnt_reg == CNT_W'(i)) begin
                sel_a = vec_a_reg[i];
                sel_b = vec_b_reg[i];
            end
        end
    end

    // Extend operands to product width; the low 2W bits of the product of
    // two extended operands is the exact full-precision result
    generate
        if (pSIGNED) begin : g_signed
            assign ext_a = {{W{sel_a[W-1]}}, sel_a};
            assign ext_b = {{W{sel_b[W-1]}}, sel_b};
        end else begin : g_unsigned
            assign ext_a = {{W{1'b0}}, sel_a};
            assign ext_b = {{W{1'b0}}, sel_b};
        end
    endgenerate

    assign prod = ext_a * ext_b;

    // Control FSM: IDLE waits for a vector, RUN emits one product per cycle.
    // odata is only written in RUN, so it holds its value between streams.
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            odata_reg    <= '0;
            odata_en_reg <= 1'b0;
            olast_reg    <= 1'b0;
            oready_reg   <= 1'b1;
            obusy_reg    <= 1'b0;
        end else begin
            odata_en_reg <= 1'b0;
            olast_reg    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.ivalid) begin
                        state_reg  <= RUN;
                        cnt_reg    <= '0;
                        oready_reg <= 1'b0;
                        obusy_reg  <= 1'b1;
                    end else begin
                        oready_reg <= 1'b1;
                        obusy_reg  <= 1'b0;
                    end
                end
                RUN: begin
                    odata_reg    <= prod;
                    odata_en_reg <= 1'b1;
                    // Busy stays high through the final strobe cycle
                    obusy_reg    <= 1'b1;
                    if (cnt_reg == CNT_LAST) begin
                        state_reg  <= IDLE;
                        cnt_reg    <= '0;
                        olast_reg  <= 1'b1;
                        oready_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    cnt_reg    <= '0;
                    oready_reg <= 1'b1;
                    obusy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.oready   = oready_reg;
    assign bus.odata    = odata_reg;
    assign bus.odata_en = odata_en_reg;
    assign bus.olast    = olast_reg;
    assign bus.obusy    = obusy_reg;

endmodule

// File: tb/tb_mult_seq_feeder.sv
// Bench for mult_seq_feeder: three instances (N=9 signed, N=9 unsigned,
// N=1 signed) share stimulus; each is compared every cycle against a
// schedule of expected products built from plain arithmetic.
module tb_mult_seq_feeder;
    localparam int W    = 8;
    localparam int NMAX = 9;

    typedef struct {
        int             cyc;
        logic [2*W-1:0] d;
        logic           last;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    int              cyc = 0;
    int              checks = 0;
    int              errors = 0;
    logic [NMAX*W-1:0] stim_a = '0;
    logic [NMAX*W-1:0] stim_b = '0;
    logic [2:0]        stim_valid = '0;

    always #5 clk = ~clk;

    // Edge counter; after edge k it reads k+1
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, expv);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int N = (gi == 2) ? 1 : 9;
        localparam bit S = (gi != 1);

        mult_seq_feeder_if #(.pDATA_IN_W(W), .pNUM_OF_ELEMENTS(N)) bus ();

        mult_seq_feeder #(
            .pDATA_IN_W(W),
            .pNUM_OF_ELEMENTS(N),
            .pSIGNED(S)
        ) dut (
            .iclk(clk),
            .irst(rst),
            .bus(bus.slave)
        );

        assign bus.idata_a = stim_a[N*W-1:0];
        assign bus.idata_b = stim_b[N*W-1:0];
        assign bus.ivalid  = stim_valid[gi];

        exp_t           q[$];
        int             next_free = 0;
        logic [2*W-1:0] last_d = '0;
        int             acc = 0;
        int             done_sum = 0;

        // Reference model: check this cycle's outputs, then decide whether the
        // upcoming edge accepts a vector and schedule its products
        always @(negedge clk or posedge rst) begin : model
            logic exp_en;
            logic exp_ready;
            int   val;
            if (rst) begin
                q.delete();
                next_free = 0;
                last_d    = '0;
                acc       = 0;
            end
            if (!clk) begin
                exp_en    = (q.size() > 0) && (q[0].cyc == cyc);
                exp_ready = (cyc >= next_free);
                check($sformatf("i%0d_odata_en@%0d", gi, cyc), bus.odata_en, exp_en);
                if (exp_en) begin
                    check($sformatf("i%0d_odata@%0d", gi, cyc), bus.odata, q[0].d);
                    check($sformatf("i%0d_olast@%0d", gi, cyc), bus.olast, q[0].last);
                    last_d = q[0].d;
                    if (S) val = int'($signed(bus.odata));
                    else   val = int'(bus.odata);
                    acc += val;
                    if (q[0].last) begin
                        done_sum = acc;
                        acc      = 0;
                    end
                    void'(q.pop_front());
                end else begin
                    check($sformatf("i%0d_hold@%0d", gi, cyc), bus.odata, last_d);
                    check($sformatf("i%0d_olast@%0d", gi, cyc), bus.olast, 1'b0);
                end
                check($sformatf("i%0d_oready@%0d", gi, cyc), bus.oready, exp_ready);
                check($sformatf("i%0d_obusy@%0d", gi, cyc), bus.obusy, !exp_ready || exp_en);
                if (!rst && bus.ivalid && exp_ready) begin
                    for (int k = 0; k < N; k++) begin
                        logic [W-1:0] a8;
                        logic [W-1:0] b8;
                        int   ai;
                        int   bi;
                        int   p;
                        exp_t e;
                        a8 = bus.idata_a[k*W +: W];
                        b8 = bus.idata_b[k*W +: W];
                        if (S) begin
                            ai = int'($signed(a8));
                            bi = int'($signed(b8));
                        end else begin
                            ai = int'({1'b0, a8});
                            bi = int'({1'b0, b8});
                        end
                        p      = ai * bi;
                        e.cyc  = cyc + 2 + k;
                        e.d    = p[2*W-1:0];
                        e.last = (k == N - 1);
                        q.push_back(e);
                    end
                    next_free = cyc + N + 1;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_elem(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        stim_a[i*W +: W] = a;
        stim_b[i*W +: W] = b;
    endtask

    task automatic rand_vec();
        for (int i = 0; i < NMAX; i++) set_elem(i, W'($urandom), W'($urandom));
    endtask

    task automatic pulse(input logic [2:0] which, input int wait_cycles);
        stim_valid = which;
        step(1);
        stim_valid = '0;
        step(wait_cycles);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        step(3);
        check("rst_oready", g_dut[0].bus.oready, 1'b1);
        check("rst_odata", g_dut[0].bus.odata, 0);
        check("rst_odata_en", g_dut[0].bus.odata_en, 1'b0);
        check("rst_obusy", g_dut[0].bus.obusy, 1'b0);
        rst = 1'b0;
        step(2);

        // Ramp times two: sum of 2..18
        for (int i = 0; i < NMAX; i++) set_elem(i, W'(i + 1), 8'd2);
        pulse(3'b111, 12);
        check("t1_sum", g_dut[0].done_sum, 90);

        // Signed and unsigned corner operands
        rand_vec();
        set_elem(0, 8'h80, 8'h80);
        set_elem(1, 8'hFF, 8'h7F);
        set_elem(2, 8'h7F, 8'h7F);
        set_elem(3, 8'hFF, 8'hFF);
        pulse(3'b111, 12);

        // Single-element instance: -3 * 5
        set_elem(0, 8'hFD, 8'h05);
        pulse(3'b100, 4);
        check("t5_sum", g_dut[2].done_sum, -15);

        // Reset in the middle of a stream (counter at 4)
        rand_vec();
        stim_valid = 3'b111;
        step(1);
        stim_valid = '0;
        step(4);
        rst = 1'b1;
        #1;
        check("t4_odata_en", g_dut[0].bus.odata_en, 1'b0);
        check("t4_odata", g_dut[0].bus.odata, 0);
        check("t4_olast", g_dut[0].bus.olast, 1'b0);
        check("t4_oready", g_dut[0].bus.oready, 1'b1);
        check("t4_obusy", g_dut[0].bus.obusy, 1'b0);
        step(2);
        rst = 1'b0;
        step(12);

        // Dot product 1..9 . 1..9
        for (int i = 0; i < NMAX; i++) set_elem(i, W'(i + 1), W'(i + 1));
        pulse(3'b111, 12);
        check("t6_dot_s", g_dut[0].done_sum, 285);
        check("t6_dot_u", g_dut[1].done_sum, 285);

        // Valid held high with fresh data every cycle
        stim_valid = 3'b111;
        for (int t = 0; t < 40; t++) begin
            rand_vec();
            step(1);
        end
        stim_valid = '0;
        step(12);

        // Random traffic
        for (int t = 0; t < 400; t++) begin
            rand_vec();
            stim_valid = 3'($urandom);
            step(1);
        end
        stim_valid = '0;
        step(15);

        check("drain_i0", g_dut[0].q.size(), 0);
        check("drain_i1", g_dut[1].q.size(), 0);
        check("drain_i2", g_dut[2].q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
